// File: rtl/periph_bus_arbiter_if.sv
// Bundle of request, response and shared-bus signals around the two-port
// peripheral bus arbiter. The slave modport is the arbiter's view; the
// master modport is the view of the requesters and the peripheral side.

`ifndef ADDR_W
`define ADDR_W 32
`endif
`ifndef WORD_W
`define WORD_W 32
`endif
`ifndef MEM_COUNT_W
`define MEM_COUNT_W 3
`endif
`ifndef MEM_CODE_W
`define MEM_CODE_W 2
`endif

interface periph_bus_arbiter_if;
    // Requester port 0
    logic                      i_p0_req_valid;
    logic [`ADDR_W-1:0]        i_p0_req_addr;
    logic [`WORD_W-1:0]        i_p0_req_wr_data;
    logic                      i_p0_req_wr_en;
    logic [`MEM_COUNT_W-1:0]   i_p0_req_count;
    logic                      o_p0_req_ready;
    logic                      o_p0_res_valid;

    // Requester port 1
    logic                      i_p1_req_valid;
    logic [`ADDR_W-1:0]        i_p1_req_addr;
    logic [`WORD_W-1:0]        i_p1_req_wr_data;
    logic                      i_p1_req_wr_en;
    logic [`MEM_COUNT_W-1:0]   i_p1_req_count;
    logic                      o_p1_req_ready;
    logic                      o_p1_res_valid;

    // Shared registered response
    logic [`WORD_W-1:0]        o_res_rd_data;
    logic [`MEM_CODE_W-1:0]    o_res_code;

    // Shared peripheral bus
    logic [`ADDR_W-1:0]        o_bus_addr;
    logic [`WORD_W-1:0]        o_bus_wr_data;
    logic                      o_bus_wr_en;
    logic [`MEM_COUNT_W-1:0]   o_bus_count;
    logic [`WORD_W-1:0]        i_bus_rd_data;
    logic [`MEM_CODE_W-1:0]    i_bus_code;

    modport slave (
        input  i_p0_req_valid, i_p0_req_addr, i_p0_req_wr_data, i_p0_req_wr_en, i_p0_req_count,
        output o_p0_req_ready, o_p0_res_valid,
        input  i_p1_req_valid, i_p1_req_addr, i_p1_req_wr_data, i_p1_req_wr_en, i_p1_req_count,
        output o_p1_req_ready, o_p1_res_valid,
        output o_res_rd_data, o_res_code,
        output o_bus_addr, o_bus_wr_data, o_bus_wr_en, o_bus_count,
        input  i_bus_rd_data, i_bus_code
    );

    modport master (
        output i_p0_req_valid, i_p0_req_addr, i_p0_req_wr_data, i_p0_req_wr_en, i_p0_req_count,
        input  o_p0_req_ready, o_p0_res_valid,
        output i_p1_req_valid, i_p1_req_addr, i_p1_req_wr_data, i_p1_req_wr_en, i_p1_req_count,
        input  o_p1_req_ready, o_p1_res_valid,
        input  o_res_rd_data, o_res_code,
        input  o_bus_addr, o_bus_wr_data, o_bus_wr_en, o_bus_count,
        output i_bus_rd_data, i_bus_code
    );
endinterface

// File: rtl/periph_bus_arbiter.sv
// Two-port arbiter for the shared memory-mapped peripheral bus. Each
// transaction takes IDLE -> BUSY -> RESP: the bus is driven for the single
// BUSY cycle, the peripheral's combinational response is registered at the
// end of BUSY, and the winning port sees res_valid during RESP.

module periph_bus_arbiter #(
    parameter int unsigned FIXED_PRIORITY = 0
) (
    input logic                 clk,
    input logic                 aresetn,
    periph_bus_arbiter_if.slave bus_if
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic                     grant_q, grant_d;
    logic                     last_grant_q, last_grant_d;
    logic [`WORD_W-1:0]       rd_data_q, rd_data_d;
    logic [`MEM_CODE_W-1:0]   code_q, code_d;

    logic                     winner;
    logic [`ADDR_W-1:0]       bus_addr;
    logic [`WORD_W-1:0]       bus_wr_data;
    logic                     bus_wr_en;
    logic [`MEM_COUNT_W-1:0]  bus_count;
    logic                     p0_ready;
    logic                     p1_ready;
    logic                     p0_res_valid;
    logic                     p1_res_valid;

    // Winner selection: a lone requester wins; on a tie either port 0 wins
    // outright or the port that was not served last time wins.
    always_comb begin
        winner = 1'b0;
        if (bus_if.i_p0_req_valid && bus_if.i_p1_req_valid) begin
            winner = (FIXED_PRIORITY != 0) ? 1'b0 : ~last_grant_q;
        end else if (bus_if.i_p1_req_valid) begin
            winner = 1'b1;
        end
    end

    // Next-state and output decode; the bus is quiet except during BUSY.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        rd_data_d    = rd_data_q;
        code_d       = code_q;
        bus_addr     = '0;
        bus_wr_data  = '0;
        bus_wr_en    = 1'b0;
        bus_count    = '0;
        p0_ready     = 1'b0;
        p1_ready     = 1'b0;
        p0_res_valid = 1'b0;
        p1_res_valid = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus_if.i_p0_req_valid || bus_if.i_p1_req_valid) begin
                    grant_d = winner;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (grant_q) begin
                    bus_addr    = bus_if.i_p1_req_addr;
                    bus_wr_data = bus_if.i_p1_req_wr_data;
                    bus_wr_en   = bus_if.i_p1_req_wr_en;
                    bus_count   = bus_if.i_p1_req_count;
                    p1_ready    = 1'b1;
                end else begin
                    bus_addr    = bus_if.i_p0_req_addr;
                    bus_wr_data = bus_if.i_p0_req_wr_data;
                    bus_wr_en   = bus_if.i_p0_req_wr_en;
                    bus_count   = bus_if.i_p0_req_count;
                    p0_ready    = 1'b1;
                end
                rd_data_d    = bus_if.i_bus_rd_data;
                code_d       = bus_if.i_bus_code;
                last_grant_d = grant_q;
                state_d      = RESP;
            end
            RESP: begin
                p0_res_valid = ~grant_q;
                p1_res_valid = grant_q;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and response registers; last_grant resets to 1 so port 0 takes
    // the first tie after reset.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            rd_data_q    <= '0;
            code_q       <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            rd_data_q    <= rd_data_d;
            code_q       <= code_d;
        end
    end

    assign bus_if.o_bus_addr     = bus_addr;
    assign bus_if.o_bus_wr_data  = bus_wr_data;
    assign bus_if.o_bus_wr_en    = bus_wr_en;
    assign bus_if.o_bus_count    = bus_count;
    assign bus_if.o_p0_req_ready = p0_ready;
    assign bus_if.o_p1_req_ready = p1_ready;
    assign bus_if.o_p0_res_valid = p0_res_valid;
    assign bus_if.o_p1_res_valid = p1_res_valid;
    assign bus_if.o_res_rd_data  = rd_data_q;
    assign bus_if.o_res_code     = code_q;

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Directed bench for periph_bus_arbiter. Two instances share the same
// requester stimulus: dut_rr (round-robin) and dut_fp (fixed priority).
// A small register-file peripheral answers on dut_rr's bus.

`ifndef ADDR_W
`define ADDR_W 32
`endif
`ifndef WORD_W
`define WORD_W 32
`endif
`ifndef MEM_COUNT_W
`define MEM_COUNT_W 3
`endif
`ifndef MEM_CODE_W
`define MEM_CODE_W 2
`endif

module tb_periph_bus_arbiter;

    logic clk;
    logic aresetn;
    int   errors;
    int   checks;

    logic [31:0] mem [16];

    periph_bus_arbiter_if if_rr ();
    periph_bus_arbiter_if if_fp ();

    periph_bus_arbiter #(.FIXED_PRIORITY(0)) dut_rr (
        .clk     (clk),
        .aresetn (aresetn),
        .bus_if  (if_rr.slave)
    );

    periph_bus_arbiter #(.FIXED_PRIORITY(1)) dut_fp (
        .clk     (clk),
        .aresetn (aresetn),
        .bus_if  (if_fp.slave)
    );

    // Clock: 10 time-unit period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Fixed-priority instance mirrors the round-robin instance's requesters
    assign if_fp.i_p0_req_valid   = if_rr.i_p0_req_valid;
    assign if_fp.i_p0_req_addr    = if_rr.i_p0_req_addr;
    assign if_fp.i_p0_req_wr_data = if_rr.i_p0_req_wr_data;
    assign if_fp.i_p0_req_wr_en   = if_rr.i_p0_req_wr_en;
    assign if_fp.i_p0_req_count   = if_rr.i_p0_req_count;
    assign if_fp.i_p1_req_valid   = if_rr.i_p1_req_valid;
    assign if_fp.i_p1_req_addr    = if_rr.i_p1_req_addr;
    assign if_fp.i_p1_req_wr_data = if_rr.i_p1_req_wr_data;
    assign if_fp.i_p1_req_wr_en   = if_rr.i_p1_req_wr_en;
    assign if_fp.i_p1_req_count   = if_rr.i_p1_req_count;

    // Peripheral: 16 word registers, combinational read, addresses >= 0x40
    // answer with code 3 (unmapped).
    assign if_rr.i_bus_rd_data = mem[if_rr.o_bus_addr[5:2]];
    assign if_rr.i_bus_code    = (if_rr.o_bus_addr >= 32'h40) ? 2'd3 : 2'd0;
    assign if_fp.i_bus_rd_data = mem[if_fp.o_bus_addr[5:2]];
    assign if_fp.i_bus_code    = (if_fp.o_bus_addr >= 32'h40) ? 2'd3 : 2'd0;

    // Peripheral registers reset to 0x1000+index, register 4 holds 0xCAFE;
    // writes from the round-robin instance land at the clock edge.
    always @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'h1000 + i;
            mem[4] <= 32'h0000_CAFE;
        end else if (if_rr.o_bus_wr_en && if_rr.o_bus_count != 0) begin
            mem[if_rr.o_bus_addr[5:2]] <= if_rr.o_bus_wr_data;
        end
    end

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input bit port, input bit valid, input logic [31:0] addr,
                                  input logic [31:0] data, input bit wr_en);
        if (port == 1'b0) begin
            if_rr.i_p0_req_valid   = valid;
            if_rr.i_p0_req_addr    = addr;
            if_rr.i_p0_req_wr_data = data;
            if_rr.i_p0_req_wr_en   = wr_en;
            if_rr.i_p0_req_count   = valid ? 3'd4 : 3'd0;
        end else begin
            if_rr.i_p1_req_valid   = valid;
            if_rr.i_p1_req_addr    = addr;
            if_rr.i_p1_req_wr_data = data;
            if_rr.i_p1_req_wr_en   = wr_en;
            if_rr.i_p1_req_count   = valid ? 3'd4 : 3'd0;
        end
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        aresetn = 1'b0;
        apply_stimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        apply_stimulus(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);

        // Reset state
        repeat (2) tick();
        check_output("rst_p0_ready", if_rr.o_p0_req_ready, 0);
        check_output("rst_p1_ready", if_rr.o_p1_req_ready, 0);
        check_output("rst_p0_resv",  if_rr.o_p0_res_valid, 0);
        check_output("rst_bus_count", if_rr.o_bus_count, 0);
        check_output("rst_rd_data",  if_rr.o_res_rd_data, 0);
        check_output("rst_code",     if_rr.o_res_code, 0);
        aresetn = 1'b1;

        // p0 write 0x1234 to 0x8
        apply_stimulus(1'b0, 1'b1, 32'h8, 32'h1234, 1'b1);
        #1;
        check_output("idle_bus_quiet", if_rr.o_bus_count, 0);
        check_output("idle_no_ready", if_rr.o_p0_req_ready, 0);
        tick();
        check_output("w1_bus_addr", if_rr.o_bus_addr, 32'h8);
        check_output("w1_bus_data", if_rr.o_bus_wr_data, 32'h1234);
        check_output("w1_bus_wr_en", if_rr.o_bus_wr_en, 1);
        check_output("w1_bus_count", if_rr.o_bus_count, 4);
        check_output("w1_p0_ready", if_rr.o_p0_req_ready, 1);
        check_output("w1_p1_ready", if_rr.o_p1_req_ready, 0);
        tick();
        check_output("w1_p0_resv", if_rr.o_p0_res_valid, 1);
        check_output("w1_p1_resv", if_rr.o_p1_res_valid, 0);
        check_output("w1_resp_bus_count", if_rr.o_bus_count, 0);
        check_output("w1_p0_ready_off", if_rr.o_p0_req_ready, 0);
        check_output("w1_rd_data_old", if_rr.o_res_rd_data, 32'h1002);
        check_output("w1_mem", mem[2], 32'h1234);
        apply_stimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        check_output("w1_resv_pulse", if_rr.o_p0_res_valid, 0);

        // p0 read back 0x8
        apply_stimulus(1'b0, 1'b1, 32'h8, 32'h0, 1'b0);
        tick();
        tick();
        check_output("rb_rd_data", if_rr.o_res_rd_data, 32'h1234);
        check_output("rb_code", if_rr.o_res_code, 0);
        apply_stimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        tick();

        // p1 read 0x10 returning 0xCAFE
        apply_stimulus(1'b1, 1'b1, 32'h10, 32'h0, 1'b0);
        tick();
        check_output("r1_p1_ready", if_rr.o_p1_req_ready, 1);
        check_output("r1_p0_ready", if_rr.o_p0_req_ready, 0);
        check_output("r1_bus_addr", if_rr.o_bus_addr, 32'h10);
        check_output("r1_bus_wr_en", if_rr.o_bus_wr_en, 0);
        tick();
        check_output("r1_p1_resv", if_rr.o_p1_res_valid, 1);
        check_output("r1_p0_resv", if_rr.o_p0_res_valid, 0);
        check_output("r1_rd_data", if_rr.o_res_rd_data, 32'hCAFE);
        apply_stimulus(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        check_output("r1_resv_pulse", if_rr.o_p1_res_valid, 0);

        // Write after read: response data follows the write's bus sample
        apply_stimulus(1'b0, 1'b1, 32'hC, 32'hBEEF, 1'b1);
        tick();
        check_output("w2_hold_rd_data", if_rr.o_res_rd_data, 32'hCAFE);
        tick();
        check_output("w2_rd_data", if_rr.o_res_rd_data, 32'h1003);
        check_output("w2_resp_bus_count", if_rr.o_bus_count, 0);
        check_output("w2_resp_bus_addr", if_rr.o_bus_addr, 0);
        apply_stimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        check_output("w2_idle_wr_en", if_rr.o_bus_wr_en, 0);
        check_output("w2_mem", mem[3], 32'hBEEF);

        // Unmapped address: response code passed through
        apply_stimulus(1'b1, 1'b1, 32'h80, 32'h0, 1'b0);
        tick();
        tick();
        check_output("um_code", if_rr.o_res_code, 3);
        check_output("um_rd_data", if_rr.o_res_rd_data, 32'h1000);
        apply_stimulus(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        tick();

        // Both ports continuously valid: round-robin alternates, fixed
        // priority always serves port 0
        apply_stimulus(1'b0, 1'b1, 32'h8, 32'h0, 1'b0);
        apply_stimulus(1'b1, 1'b1, 32'h10, 32'h0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check_output($sformatf("rr_p0_ready_%0d", k), if_rr.o_p0_req_ready, (k % 2 == 0));
            check_output($sformatf("rr_p1_ready_%0d", k), if_rr.o_p1_req_ready, (k % 2 == 1));
            check_output($sformatf("fp_p0_ready_%0d", k), if_fp.o_p0_req_ready, 1);
            check_output($sformatf("fp_p1_ready_%0d", k), if_fp.o_p1_req_ready, 0);
            tick();
            check_output($sformatf("rr_p1_resv_%0d", k), if_rr.o_p1_res_valid, (k % 2 == 1));
            check_output($sformatf("rr_rd_data_%0d", k), if_rr.o_res_rd_data,
                         (k % 2 == 0) ? 32'h1234 : 32'hCAFE);
            tick();
            check_output($sformatf("rr_idle_ready_%0d", k), if_rr.o_p0_req_ready | if_rr.o_p1_req_ready, 0);
        end

        // Reset during BUSY aborts the transaction
        apply_stimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        check_output("ab_p1_ready", if_rr.o_p1_req_ready, 1);
        aresetn = 1'b0;
        #1;
        check_output("ab_ready_cleared", if_rr.o_p1_req_ready, 0);
        check_output("ab_bus_count", if_rr.o_bus_count, 0);
        check_output("ab_rd_data", if_rr.o_res_rd_data, 0);
        tick();
        check_output("ab_no_resv", if_rr.o_p1_res_valid, 0);
        aresetn = 1'b1;
        tick();
        check_output("ab_regrant_p1", if_rr.o_p1_req_ready, 1);
        check_output("ab_regrant_addr", if_rr.o_bus_addr, 32'h10);
        tick();
        check_output("ab_regrant_resv", if_rr.o_p1_res_valid, 1);
        check_output("ab_regrant_data", if_rr.o_res_rd_data, 32'hCAFE);

        // Serve p0 so last_grant=0, then reset and check first tie goes to p0
        apply_stimulus(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        apply_stimulus(1'b0, 1'b1, 32'h8, 32'h0, 1'b0);
        tick();
        tick();
        check_output("pre_p0_ready", if_rr.o_p0_req_ready, 1);
        tick();
        apply_stimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        aresetn = 1'b0;
        #2;
        aresetn = 1'b1;
        apply_stimulus(1'b0, 1'b1, 32'h8, 32'h0, 1'b0);
        apply_stimulus(1'b1, 1'b1, 32'h10, 32'h0, 1'b0);
        tick();
        check_output("tie_p0_ready", if_rr.o_p0_req_ready, 1);
        check_output("tie_p1_ready", if_rr.o_p1_req_ready, 0);
        tick();
        apply_stimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        apply_stimulus(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
